// File: rtl/uart_arb_pkg.sv
// uart_arb_pkg: shared types and constants for the UART TX FIFO arbiter.
//   arb_state_e  - arbiter FSM states
//   rel_cause_e  - reason the last grant was released (encoding is visible
//                  on the release_cause port)
//   CNT_W        - width of the beat and idle counters
package uart_arb_pkg;

  typedef enum logic {
    ARB_IDLE  = 1'b0,
    ARB_GRANT = 1'b1
  } arb_state_e;

  typedef enum logic [1:0] {
    REL_LAST    = 2'd0,
    REL_BURST   = 2'd1,
    REL_TIMEOUT = 2'd2,
    REL_DISABLE = 2'd3
  } rel_cause_e;

  localparam int CNT_W = 8;

endpackage

// File: rtl/rr_pick.sv
// rr_pick: combinational round-robin priority picker.
//   req_i   - request vector
//   ptr_i   - index searched first; the search continues upward with wrap
//   found_o - at least one request bit is set
//   idx_o   - index of the first set bit at or after ptr_i (0 when none)
module rr_pick #(
  parameter  int N    = 4,
  localparam int ID_W = $clog2(N)
) (
  input  logic [N-1:0]    req_i,
  input  logic [ID_W-1:0] ptr_i,
  output logic            found_o,
  output logic [ID_W-1:0] idx_o
);

  // Walk N positions starting at ptr_i; the first set bit wins.
  always_comb begin
    logic [ID_W:0] pos;
    logic          hit;
    found_o = 1'b0;
    idx_o   = '0;
    pos     = '0;
    hit     = 1'b0;
    for (int k = 0; k < N; k++) begin
      pos     = {1'b0, ptr_i} + (ID_W+1)'(k);
      pos     = (pos >= (ID_W+1)'(N)) ? pos - (ID_W+1)'(N) : pos;
      hit     = req_i[pos[ID_W-1:0]] && !found_o;
      idx_o   = hit ? pos[ID_W-1:0] : idx_o;
      found_o = found_o | req_i[pos[ID_W-1:0]];
    end
  end

endmodule

// File: rtl/uart_tx_arbiter.sv
// uart_tx_arbiter: shares the UART TX FIFO push port between NUM_REQ
// byte-stream requesters with round-robin packet arbitration. A grant is
// held until end-of-packet, MAX_BURST beats, IDLE_TIMEOUT idle cycles or
// the holder being disabled; one IDLE bubble separates consecutive grants.
// Ports:
//   PCLK, PRESET       - clock, synchronous active-high reset
//   req_en             - per-requester enable mask
//   req_valid/req_data/req_last/req_ready - per-requester byte streams
//   fifo_full/fifo_push/fifo_wdata        - TX FIFO push interface
//   grant_valid/grant_id                  - current grant holder
//   release_cause      - reason the last grant ended (rel_cause_e)
module uart_tx_arbiter
  import uart_arb_pkg::*;
#(
  parameter  int NUM_REQ      = 4,
  parameter  int DATA_W       = 8,
  parameter  int MAX_BURST    = 16,
  parameter  int IDLE_TIMEOUT = 32,
  localparam int ID_W         = $clog2(NUM_REQ)
) (
  input  logic                      PCLK,
  input  logic                      PRESET,
  input  logic [NUM_REQ-1:0]        req_en,
  input  logic [NUM_REQ-1:0]        req_valid,
  input  logic [NUM_REQ*DATA_W-1:0] req_data,
  input  logic [NUM_REQ-1:0]        req_last,
  output logic [NUM_REQ-1:0]        req_ready,
  input  logic                      fifo_full,
  output logic                      fifo_push,
  output logic [DATA_W-1:0]         fifo_wdata,
  output logic                      grant_valid,
  output logic [ID_W-1:0]           grant_id,
  output logic [1:0]                release_cause
);

  localparam logic [CNT_W-1:0] BURST_LIM = CNT_W'(MAX_BURST);
  localparam logic [CNT_W-1:0] TMO_LIM   = CNT_W'(IDLE_TIMEOUT);

  arb_state_e       state_q, state_d;
  logic [ID_W-1:0]  rr_ptr_q, rr_ptr_d;
  logic [ID_W-1:0]  grant_id_q, grant_id_d;
  logic [CNT_W-1:0] beat_cnt_q, beat_cnt_d;
  logic [CNT_W-1:0] idle_cnt_q, idle_cnt_d;
  rel_cause_e       cause_q, cause_d;

  logic [NUM_REQ-1:0] cand;
  logic               pick_found;
  logic [ID_W-1:0]    pick_idx;
  logic [DATA_W-1:0]  data_arr [NUM_REQ];
  logic               in_grant, en_g, valid_g, last_g, ready_g, push_g, idle_g;
  logic [DATA_W-1:0]  data_g;
  logic [CNT_W-1:0]   beat_inc, idle_inc;

  // Disabled requesters never become candidates, even while valid.
  assign cand = req_valid & req_en;

  rr_pick #(.N(NUM_REQ)) u_pick (
    .req_i   (cand),
    .ptr_i   (rr_ptr_q),
    .found_o (pick_found),
    .idx_o   (pick_idx)
  );

  // Unpack the flat data bus into one byte per requester.
  always_comb begin
    for (int i = 0; i < NUM_REQ; i++) begin
      data_arr[i] = req_data[i*DATA_W +: DATA_W];
    end
  end

  // Holder's handshake signals; a full FIFO stalls without counting idle.
  always_comb begin
    in_grant = (state_q == ARB_GRANT);
    en_g     = req_en[grant_id_q];
    valid_g  = req_valid[grant_id_q];
    last_g   = req_last[grant_id_q];
    data_g   = data_arr[grant_id_q];
    ready_g  = in_grant && !fifo_full && en_g;
    push_g   = ready_g && valid_g;
    idle_g   = in_grant && !valid_g;
    beat_inc = beat_cnt_q + CNT_W'(1);
    idle_inc = idle_cnt_q + CNT_W'(1);
  end

  // State register.
  always_ff @(posedge PCLK) begin
    if (PRESET) begin
      state_q    <= ARB_IDLE;
      rr_ptr_q   <= '0;
      grant_id_q <= '0;
      beat_cnt_q <= '0;
      idle_cnt_q <= '0;
      cause_q    <= REL_LAST;
    end else begin
      state_q    <= state_d;
      rr_ptr_q   <= rr_ptr_d;
      grant_id_q <= grant_id_d;
      beat_cnt_q <= beat_cnt_d;
      idle_cnt_q <= idle_cnt_d;
      cause_q    <= cause_d;
    end
  end

  // Next-state logic: grant selection, release priority and counters.
  always_comb begin
    logic       rel;
    rel_cause_e rel_why;
    state_d    = state_q;
    rr_ptr_d   = rr_ptr_q;
    grant_id_d = grant_id_q;
    beat_cnt_d = beat_cnt_q;
    idle_cnt_d = idle_cnt_q;
    cause_d    = cause_q;
    rel        = 1'b0;
    rel_why    = REL_LAST;
    case (state_q)
      ARB_IDLE: begin
        if (pick_found) begin
          state_d    = ARB_GRANT;
          grant_id_d = pick_idx;
          beat_cnt_d = '0;
          idle_cnt_d = '0;
        end else begin
          state_d = ARB_IDLE;
        end
      end
      ARB_GRANT: begin
        // Last beats the burst limit when both land on the same push.
        if (push_g && last_g) begin
          rel = 1'b1; rel_why = REL_LAST;
        end else if (push_g && (beat_inc == BURST_LIM)) begin
          rel = 1'b1; rel_why = REL_BURST;
        end else if (!en_g) begin
          rel = 1'b1; rel_why = REL_DISABLE;
        end else if (idle_g && (idle_inc == TMO_LIM)) begin
          rel = 1'b1; rel_why = REL_TIMEOUT;
        end else if (push_g) begin
          beat_cnt_d = beat_inc;
          idle_cnt_d = '0;
        end else if (idle_g) begin
          idle_cnt_d = idle_inc;
        end else begin
          beat_cnt_d = beat_cnt_q;
        end
        if (rel) begin
          state_d  = ARB_IDLE;
          cause_d  = rel_why;
          rr_ptr_d = (grant_id_q == ID_W'(NUM_REQ-1)) ? '0 : grant_id_q + ID_W'(1);
        end else begin
          state_d = ARB_GRANT;
        end
      end
      default: begin
        state_d = ARB_IDLE;
      end
    endcase
  end

  // Output logic: zero-latency pass-through of the holder's byte.
  always_comb begin
    req_ready  = '0;
    fifo_push  = 1'b0;
    fifo_wdata = '0;
    case (state_q)
      ARB_GRANT: begin
        req_ready[grant_id_q] = ready_g;
        fifo_push             = push_g;
        fifo_wdata            = data_g;
      end
      default: begin
        fifo_push = 1'b0;
      end
    endcase
  end

  assign grant_valid   = in_grant;
  assign grant_id      = grant_id_q;
  assign release_cause = cause_q;

endmodule
